doorlock_keypad_ctrl: RTL and testbench
=======================================

# doorlock_keypad_ctrl

Keypad-side controller for the door lock. Debounce-free pushbutton front end (2-flop sync plus edge detect) assembles a 4-bit code from `0`/`1` keys and drives the lock's `state[1:0]`/`ps_num[3:0]` command inputs. It sequences the lock through hold-idle (00), load (01) and check (10). It samples the lock's `door_open` response, holds the door open for a fixed time, counts failed attempts and enforces a lockout.

## Interface
- `OPEN_CYCLES`, 100: cycles `state` stays 10 after a successful open.
- `MAX_FAIL`, 3: consecutive failed attempts that trigger lockout (1..7).
- `LOCK_CYCLES`, 200: lockout duration in cycles.
- `clk` in 1: single clock, all flops rising-edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `btn0` in 1: raw key "0", active-high, asynchronous to `clk`.
- `btn1` in 1: raw key "1".
- `btn_enter` in 1: raw enter key.
- `btn_clear` in 1: raw clear key.
- `door_open` in 1: lock response.
- `state` out 2: lock command; 00 idle, 01 load, 10 check.
- `ps_num` out 4: code buffer, MSB = oldest bit.
- `digit_cnt` out 3: bits entered, 0..4.
- `locked_out` out 1: high during lockout.
- `busy` out 1: high in LOAD, CHECK, OPEN, LOCKOUT.

## Operation
- Each button passes through a 2-flop synchronizer and a third history flop. The press pulse is `sync2 & ~sync3`, one cycle per rising edge. Holding a button produces exactly one pulse.
- One action per cycle. Priority when pulses coincide: clear > enter > btn1 > btn0. Lower-priority pulses in that cycle are dropped.
- FSM states: IDLE, LOAD, CHECK, OPEN, LOCKOUT.
- IDLE (`state`=00):
  - btn0/btn1: `ps_num <= {ps_num[2:0], bit}` and `digit_cnt++`, only while `digit_cnt`<4. A fifth and later bit is ignored.
  - clear: `ps_num`=0, `digit_cnt`=0.
  - enter with `digit_cnt`<4: acts as clear. No attempt is made and the fail count is unchanged.
  - enter with `digit_cnt`==4: go to LOAD.
- LOAD (`state`=01): one cycle, `ps_num` held stable, then CHECK.
- CHECK (`state`=10): two cycles; `door_open` is sampled on the second.
  - Sampled 1: fail_cnt=0, go to OPEN.
  - Sampled 0: fail_cnt++. If the new count == `MAX_FAIL`, go to LOCKOUT and fail_cnt=0. Otherwise go to IDLE.
- OPEN (`state`=10): hold for `OPEN_CYCLES` cycles, then IDLE.
- LOCKOUT (`state`=00, `locked_out`=1): hold for `LOCK_CYCLES` cycles, then IDLE.
- Any exit to IDLE clears `ps_num` and `digit_cnt`.
- All key pulses are discarded in LOAD, CHECK, OPEN and LOCKOUT, including clear.
- Timers are `$clog2(N+1)`-bit down-counters loaded on state entry. The state is left on the cycle the counter reads 1, giving exactly N cycles in the state.
- fail_cnt is 3 bits. It persists across attempts until a success, a lockout, or reset.

## Timing
- Reset values (async): `state`=00, `ps_num`=0, `digit_cnt`=0, `locked_out`=0, `busy`=0, FSM=IDLE, fail_cnt=0, all sync/history flops 0.
- Reset asserted mid-attempt (any state) forces the reset values immediately. There is no pending action after release.
- Key latency: a button high before clock edge e1 updates `ps_num`/`digit_cnt` at edge e3.
- Attempt timeline from the edge where enter takes effect (edge E):
  - `state`=01 during [E, E+1).
  - `state`=10 during [E+1, E+3).
  - `door_open` is sampled at E+3.
  - Success: `state`=10 continues for `OPEN_CYCLES` more cycles, then 00.
  - Failure: `state`=00 from E+3.
- All outputs are registered; there is no combinational input-to-output path.

## Test plan
- Enter 1,1,0,1 then enter, with the lock model opening on 1101:
  - `state` shows 00→01 (1 cycle)→10.
  - `ps_num`=1101 during LOAD.
  - After success, `state`=10 for 2+100 cycles total, then 00 with `ps_num`=0.
- Wrong code 0000, three times, lock model returns 0:
  - The first two attempts return to IDLE.
  - The third sets `locked_out`=1 for 200 cycles.
  - A key pressed during lockout leaves `digit_cnt`=0.
- Enter 1,0 then enter: no LOAD, `digit_cnt`→0, and fail_cnt is unchanged (verify with two wrong attempts plus this; still no lockout).
- btn1 held for 50 cycles: `digit_cnt` increments once. Then 5 more presses saturate `digit_cnt`=4 and `ps_num`=1111.
- btn_clear and btn1 pulse in the same cycle with `digit_cnt`=2: result `digit_cnt`=0, `ps_num`=0.
- `rst_n` low during OPEN: all outputs are at reset values immediately; after release, a fresh 4-bit entry works normally.

Source files
------------

// File: rtl/doorlock_keypad_ctrl.sv
// Keypad-side controller for the door lock: synchronises raw keys, assembles a
// 4-bit code and sequences the lock through load/check, open hold and lockout.
module doorlock_keypad_ctrl #(
   parameter int OPEN_CYCLES = 100,
   parameter int MAX_FAIL    = 3,
   parameter int LOCK_CYCLES = 200
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       btn0,
   input  logic       btn1,
   input  logic       btn_enter,
   input  logic       btn_clear,
   input  logic       door_open,
   output logic [1:0] state,
   output logic [3:0] ps_num,
   output logic [2:0] digit_cnt,
   output logic       locked_out,
   output logic       busy
);

   localparam int MAX_T0 = (OPEN_CYCLES > LOCK_CYCLES) ? OPEN_CYCLES : LOCK_CYCLES;
   localparam int MAX_T  = (MAX_T0 > 2) ? MAX_T0 : 2;
   localparam int TW     = $clog2(MAX_T + 1);

   localparam logic [TW-1:0] OPEN_LD    = TW'(OPEN_CYCLES);
   localparam logic [TW-1:0] LOCK_LD    = TW'(LOCK_CYCLES);
   localparam logic [TW-1:0] CHECK_LD   = TW'(2);
   localparam logic [TW-1:0] T_ONE      = TW'(1);
   localparam logic [2:0]    MAX_FAIL_C = 3'(MAX_FAIL);

   localparam logic [1:0] CMD_IDLE  = 2'b00;
   localparam logic [1:0] CMD_LOAD  = 2'b01;
   localparam logic [1:0] CMD_CHECK = 2'b10;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_LOAD    = 3'd1,
      S_CHECK   = 3'd2,
      S_OPEN    = 3'd3,
      S_LOCKOUT = 3'd4
   } fsm_t;

   // Key vector order: {clear, enter, one, zero}
   logic [3:0] raw_keys;
   logic [3:0] sync1_q, sync2_q, sync3_q;
   logic [3:0] pulse;

   fsm_t          fsm_q, fsm_d;
   logic [3:0]    ps_q, ps_d;
   logic [2:0]    cnt_q, cnt_d;
   logic [2:0]    fail_q, fail_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [1:0]    state_q, state_d;
   logic          locked_q, locked_d;
   logic          busy_q, busy_d;

   assign raw_keys = {btn_clear, btn_enter, btn1, btn0};
   assign pulse    = sync2_q & ~sync3_q;

   always_comb begin
      fsm_d   = fsm_q;
      ps_d    = ps_q;
      cnt_d   = cnt_q;
      fail_d  = fail_q;
      timer_d = timer_q;
      case (fsm_q)
         S_IDLE: begin
            if (pulse[3]) begin
               ps_d  = 4'd0;
               cnt_d = 3'd0;
            end else if (pulse[2]) begin
               if (cnt_q == 3'd4) begin
                  fsm_d = S_LOAD;
               end else begin
                  ps_d  = 4'd0;
                  cnt_d = 3'd0;
               end
            end else if (pulse[1] || pulse[0]) begin
               // pulse[1] doubles as the shifted bit, so "one" wins over "zero"
               if (cnt_q < 3'd4) begin
                  ps_d  = {ps_q[2:0], pulse[1]};
                  cnt_d = cnt_q + 3'd1;
               end
            end
         end
         S_LOAD: begin
            fsm_d   = S_CHECK;
            timer_d = CHECK_LD;
         end
         S_CHECK: begin
            if (timer_q == T_ONE) begin
               if (door_open) begin
                  fail_d  = 3'd0;
                  fsm_d   = S_OPEN;
                  timer_d = OPEN_LD;
               end else if (fail_q + 3'd1 == MAX_FAIL_C) begin
                  fail_d  = 3'd0;
                  fsm_d   = S_LOCKOUT;
                  timer_d = LOCK_LD;
                  ps_d    = 4'd0;
                  cnt_d   = 3'd0;
               end else begin
                  fail_d = fail_q + 3'd1;
                  fsm_d  = S_IDLE;
                  ps_d   = 4'd0;
                  cnt_d  = 3'd0;
               end
            end else begin
               timer_d = timer_q - T_ONE;
            end
         end
         S_OPEN, S_LOCKOUT: begin
            if (timer_q == T_ONE) begin
               fsm_d = S_IDLE;
               ps_d  = 4'd0;
               cnt_d = 3'd0;
            end else begin
               timer_d = timer_q - T_ONE;
            end
         end
         default: begin
            fsm_d = S_IDLE;
            ps_d  = 4'd0;
            cnt_d = 3'd0;
         end
      endcase
   end

   // Outputs are decoded from the next state so they register in step with it
   always_comb begin
      state_d  = CMD_IDLE;
      locked_d = 1'b0;
      busy_d   = (fsm_d != S_IDLE);
      case (fsm_d)
         S_LOAD:           state_d = CMD_LOAD;
         S_CHECK, S_OPEN:  state_d = CMD_CHECK;
         S_LOCKOUT:        locked_d = 1'b1;
         default:          state_d = CMD_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q  <= 4'd0;
         sync2_q  <= 4'd0;
         sync3_q  <= 4'd0;
         fsm_q    <= S_IDLE;
         ps_q     <= 4'd0;
         cnt_q    <= 3'd0;
         fail_q   <= 3'd0;
         timer_q  <= '0;
         state_q  <= CMD_IDLE;
         locked_q <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         sync1_q  <= raw_keys;
         sync2_q  <= sync1_q;
         sync3_q  <= sync2_q;
         fsm_q    <= fsm_d;
         ps_q     <= ps_d;
         cnt_q    <= cnt_d;
         fail_q   <= fail_d;
         timer_q  <= timer_d;
         state_q  <= state_d;
         locked_q <= locked_d;
         busy_q   <= busy_d;
      end
   end

   assign state      = state_q;
   assign ps_num     = ps_q;
   assign digit_cnt  = cnt_q;
   assign locked_out = locked_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_doorlock_keypad_ctrl.sv
// Directed bench for doorlock_keypad_ctrl with a lock model that opens on 1101.
module tb_doorlock_keypad_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       btn0 = 1'b0;
   logic       btn1 = 1'b0;
   logic       btn_enter = 1'b0;
   logic       btn_clear = 1'b0;
   logic       door_open;
   logic [1:0] state;
   logic [3:0] ps_num;
   logic [2:0] digit_cnt;
   logic       locked_out;
   logic       busy;

   int total = 0;
   int bad = 0;
   int cyc = 0;

   logic [1:0] st2, st3, st4, st5, st6;
   logic [3:0] ps3;
   logic       bsy3;

   doorlock_keypad_ctrl #(
      .OPEN_CYCLES(100),
      .MAX_FAIL(3),
      .LOCK_CYCLES(200)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .btn0(btn0),
      .btn1(btn1),
      .btn_enter(btn_enter),
      .btn_clear(btn_clear),
      .door_open(door_open),
      .state(state),
      .ps_num(ps_num),
      .digit_cnt(digit_cnt),
      .locked_out(locked_out),
      .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Lock model: accepts only code 1101 while being asked to check
   assign door_open = (state == 2'b10) && (ps_num == 4'b1101);

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_btn(input int k, input logic v);
      case (k)
         0:       btn0 = v;
         1:       btn1 = v;
         2:       btn_enter = v;
         default: btn_clear = v;
      endcase
   endtask

   task automatic press2(input int ka, input int kb);
      @(negedge clk);
      set_btn(ka, 1'b1);
      set_btn(kb, 1'b1);
      repeat (2) @(negedge clk);
      set_btn(ka, 1'b0);
      set_btn(kb, 1'b0);
      repeat (3) @(negedge clk);
   endtask

   task automatic press(input int k);
      press2(k, k);
   endtask

   task automatic press_code(input logic [3:0] code);
      for (int i = 3; i >= 0; i--) press(int'(code[i]));
   endtask

   // Samples the command lines on the negedges after the enter edge E
   task automatic enter_seq;
      @(negedge clk);
      btn_enter = 1'b1;
      @(negedge clk);
      @(negedge clk);
      st2 = state;
      btn_enter = 1'b0;
      @(negedge clk);
      st3 = state;
      ps3 = ps_num;
      bsy3 = busy;
      @(negedge clk);
      st4 = state;
      @(negedge clk);
      st5 = state;
      @(negedge clk);
      st6 = state;
   endtask

   task automatic drain(input string tag);
      int g;
      g = 0;
      while (busy === 1'b1 && g < 500) begin
         @(negedge clk);
         g++;
      end
      check(tag, {7'd0, busy}, 8'd0);
   endtask

   task automatic wrong_attempt(input string tag);
      press_code(4'b0000);
      enter_seq;
      check({tag, "_load"}, {6'd0, st3}, 8'h01);
      check({tag, "_idle"}, {6'd0, st6}, 8'h00);
      check({tag, "_nolock"}, {7'd0, locked_out}, 8'd0);
      check({tag, "_cnt"}, {5'd0, digit_cnt}, 8'd0);
   endtask

   initial begin
      int n;
      int g;
      int t0;

      // Reset values
      #1 rst_n = 1'b0;
      @(negedge clk);
      check("rst_state", {6'd0, state}, 8'h00);
      check("rst_ps", {4'd0, ps_num}, 8'h00);
      check("rst_cnt", {5'd0, digit_cnt}, 8'd0);
      check("rst_lock", {7'd0, locked_out}, 8'd0);
      check("rst_busy", {7'd0, busy}, 8'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Correct code 1101 opens the door
      press(1);
      check("e1_cnt", {5'd0, digit_cnt}, 8'd1);
      check("e1_ps", {4'd0, ps_num}, 8'h1);
      press(1);
      press(0);
      check("e3_ps", {4'd0, ps_num}, 8'h6);
      press(1);
      check("e4_cnt", {5'd0, digit_cnt}, 8'd4);
      check("e4_ps", {4'd0, ps_num}, 8'hd);
      enter_seq;
      check("ok_pre", {6'd0, st2}, 8'h00);
      check("ok_load", {6'd0, st3}, 8'h01);
      check("ok_load_ps", {4'd0, ps3}, 8'hd);
      check("ok_load_busy", {7'd0, bsy3}, 8'd1);
      check("ok_chk1", {6'd0, st4}, 8'h02);
      check("ok_chk2", {6'd0, st5}, 8'h02);
      check("ok_open", {6'd0, st6}, 8'h02);
      n = 3;
      g = 0;
      while (state === 2'b10 && g < 400) begin
         @(negedge clk);
         g++;
         if (state === 2'b10) n++;
      end
      check("ok_open_len", 8'(n), 8'd102);
      check("ok_end_state", {6'd0, state}, 8'h00);
      check("ok_end_ps", {4'd0, ps_num}, 8'h0);
      check("ok_end_busy", {7'd0, busy}, 8'd0);

      // Three wrong attempts lead to lockout
      wrong_attempt("w1");
      wrong_attempt("w2");
      press_code(4'b0000);
      enter_seq;
      check("w3_state", {6'd0, st6}, 8'h00);
      check("w3_lock", {7'd0, locked_out}, 8'd1);
      check("w3_busy", {7'd0, busy}, 8'd1);
      t0 = cyc;
      press(1);
      check("lk_key_cnt", {5'd0, digit_cnt}, 8'd0);
      check("lk_key_ps", {4'd0, ps_num}, 8'h0);
      g = 0;
      while (locked_out === 1'b1 && g < 500) begin
         @(negedge clk);
         g++;
      end
      check("lk_len", 8'(cyc - t0), 8'd200);
      check("lk_end_busy", {7'd0, busy}, 8'd0);
      check("lk_end_state", {6'd0, state}, 8'h00);

      // Short entry acts as clear and does not touch the fail count
      wrong_attempt("s1");
      wrong_attempt("s2");
      press(1);
      press(0);
      check("sh_cnt", {5'd0, digit_cnt}, 8'd2);
      check("sh_ps", {4'd0, ps_num}, 8'h2);
      enter_seq;
      check("sh_noload", {6'd0, st3}, 8'h00);
      check("sh_nobusy", {7'd0, bsy3}, 8'd0);
      check("sh_st5", {6'd0, st5}, 8'h00);
      check("sh_cnt0", {5'd0, digit_cnt}, 8'd0);
      check("sh_ps0", {4'd0, ps_num}, 8'h0);
      check("sh_nolock", {7'd0, locked_out}, 8'd0);
      press_code(4'b0000);
      enter_seq;
      check("s3_lock", {7'd0, locked_out}, 8'd1);
      drain("s3_drain");

      // Held key gives a single pulse; digits saturate at four
      @(negedge clk);
      btn1 = 1'b1;
      repeat (50) @(negedge clk);
      check("hold_cnt", {5'd0, digit_cnt}, 8'd1);
      btn1 = 1'b0;
      repeat (3) @(negedge clk);
      for (int i = 0; i < 5; i++) press(1);
      check("sat_cnt", {5'd0, digit_cnt}, 8'd4);
      check("sat_ps", {4'd0, ps_num}, 8'hf);
      press(3);
      check("clr_cnt", {5'd0, digit_cnt}, 8'd0);

      // Coincident pulses: clear > enter > one > zero
      press(1);
      press(0);
      press2(3, 1);
      check("pri_clr_cnt", {5'd0, digit_cnt}, 8'd0);
      check("pri_clr_ps", {4'd0, ps_num}, 8'h0);
      press2(0, 1);
      check("pri_b1_cnt", {5'd0, digit_cnt}, 8'd1);
      check("pri_b1_ps", {4'd0, ps_num}, 8'h1);
      press2(2, 1);
      check("pri_ent_cnt", {5'd0, digit_cnt}, 8'd0);
      check("pri_ent_busy", {7'd0, busy}, 8'd0);

      // Reset in the middle of OPEN, then a fresh attempt
      press_code(4'b1101);
      enter_seq;
      check("ro_open", {6'd0, st6}, 8'h02);
      repeat (10) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("ro_state", {6'd0, state}, 8'h00);
      check("ro_ps", {4'd0, ps_num}, 8'h0);
      check("ro_cnt", {5'd0, digit_cnt}, 8'd0);
      check("ro_busy", {7'd0, busy}, 8'd0);
      check("ro_lock", {7'd0, locked_out}, 8'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check("ro_idle", {6'd0, state}, 8'h00);
      press_code(4'b1101);
      check("ro_new_cnt", {5'd0, digit_cnt}, 8'd4);
      enter_seq;
      check("ro_new_load", {6'd0, st3}, 8'h01);
      check("ro_new_ps", {4'd0, ps3}, 8'hd);
      check("ro_new_open", {6'd0, st6}, 8'h02);
      drain("ro_drain");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
